seq_match_ctrl: RTL and testbench
=================================

# seq_match_ctrl

Programmable serial pattern-match controller for the serial-detector datapath. It holds a run-time pattern of up to PAT_W bits, arms and disarms detection on a start/stop handshake, and counts matches on a qualified serial bit stream. It reports per-match pulses and a running count, and signals completion when a programmed match target is reached. It replaces fixed-pattern detectors wherever software must choose the pattern, the overlap mode and the stop condition.

## Interface
- PAT_W, 8: maximum pattern length in bits.
- LEN_W, 4: width of the length field; must hold PAT_W.
- CNT_W, 8: match counter and target width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  configuration write strobe; honoured only in IDLE.
- cfg_pattern  in  PAT_W  pattern; bit len-1 is the first bit received.
- cfg_len  in  LEN_W  pattern length; valid range 1..PAT_W.
- cfg_overlap  in  1  1 = overlapping matches, 0 = window restarts after each match.
- cfg_target  in  CNT_W  match count that ends the run; 0 = run until stop.
- start  in  1  arm request; sampled in IDLE.
- stop  in  1  abort request; sampled in RUN.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  qualifies bit_in.
- busy  out  1  high in ARM, RUN and DONE.
- match  out  1  one-cycle pulse per detected match.
- match_cnt  out  CNT_W  matches counted in the current or last run.
- done  out  1  one-cycle pulse when the target is reached.
- cfg_err  out  1  sticky flag; set when start arrives with cfg_len = 0 or cfg_len > PAT_W.

## Operation
- FSM states: IDLE, ARM, RUN, DONE.
- IDLE:
  - cfg_we latches pattern, length, overlap and target.
  - start with a valid length clears cfg_err and moves to ARM.
  - start with an invalid length sets cfg_err and stays in IDLE.
  - start and cfg_we in the same cycle: start wins; the write is dropped and start uses the previously latched configuration.
- ARM (1 cycle): clears the history shift register, the fill counter and match_cnt, then moves to RUN. Bits arriving in ARM are ignored.
- RUN, on each bit_valid:
  - history = {history[PAT_W-2:0], bit_in}.
  - fill increments, saturating at PAT_W.
  - A match occurs when fill+1 ≥ len and the new history[len-1:0] equals pattern[len-1:0].
- On a match:
  - match pulses and match_cnt increments; the counter saturates at all-ones when cfg_target = 0.
  - If cfg_overlap = 0, fill is cleared so the next match needs len fresh bits. If cfg_overlap = 1, history and fill are retained.
  - If match_cnt reaches cfg_target (target ≠ 0), go to DONE.
- stop in RUN returns to IDLE immediately. match_cnt holds its value and done is not pulsed.
- Stop in the same cycle as a completing bit: stop wins; no match and no count update.
- DONE (1 cycle): done pulses, then the FSM returns to IDLE. match_cnt holds until the next ARM.
- The configuration registers do not change outside IDLE.

## Timing
- Reset values:
  - FSM in IDLE.
  - busy = 0, match = 0, done = 0, match_cnt = 0, cfg_err = 0.
  - pattern = 0, len = 0, overlap = 0, target = 0.
  - history and fill cleared.
- Reset is asynchronous at any point, mid-run included; outputs go to their reset values with no pulse.
- start seen in cycle T gives ARM in T+1 and RUN in T+2. busy rises in T+1.
- A bit completing a match in cycle T gives match = 1 and the updated match_cnt in T+1. All outputs are registered.
- The final match of a run gives match and the count in T+1, done in T+2, and busy low in T+3.
- bit_valid may be asserted every cycle; there is no back-pressure and no bit is dropped in RUN.

## Structure
- Package seq_match_pkg: state enum (IDLE, ARM, RUN, DONE) and the LEN_W/PAT_W legality constant.
- Sub-module seq_window_cmp:
  - Contents: history shift register, fill counter and length-masked comparator.
  - Inputs: shift, clear, cfg_overlap restart.
  - Output: a combinational hit.
- Top level: FSM, configuration registers, counter and output registers.

## Test plan
- Overlapping matches: pattern 4'b1101, len 4, overlap 1, target 0, stream 1,1,0,1,1,0,1 → match after bits 4 and 7; match_cnt = 2.
- Non-overlapping matches: same stream with overlap 0 → one match after bit 4; match_cnt = 1.
- Target reached: overlap 1, target 2, same stream → done pulses 1 cycle after the second match; busy drops the next cycle; further bits produce no match.
- Invalid length: cfg_len = 0 then start → cfg_err = 1, busy stays 0. Then a valid cfg_len = 3 and start → cfg_err clears.
- Stop collision: stop asserted in the same cycle as a completing bit → no match pulse; match_cnt is unchanged; FSM in IDLE next cycle.
- Reset mid-run: rst_n low during RUN after 1 match → all outputs 0 asynchronously. After release, a new start counts from 0.

Source files
------------

// File: rtl/seq_match_pkg.sv
// rtl/seq_match_pkg.sv - state encoding and pattern-length legality check for seq_match_ctrl
package seq_match_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // A programmed length is usable only if it names at least one bit and fits the window.
  function automatic logic len_legal(input int len, input int pat_w);
    return (len >= 1) && (len <= pat_w);
  endfunction

endpackage

// File: rtl/seq_window_cmp.sv
// rtl/seq_window_cmp.sv - history shift register, fill counter and length-masked pattern compare
module seq_window_cmp #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift,
  input  logic             restart,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             hit
);

  localparam logic [LEN_W:0] FILL_MAX = (LEN_W+1)'(PAT_W);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_nx;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill;
  logic [LEN_W:0]   fill_inc;

  assign hist_nx  = {hist[PAT_W-2:0], bit_in};
  assign fill_inc = {1'b0, fill} + (LEN_W+1)'(1);

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  // Hit is judged on the history as it will be after this bit is shifted in.
  assign hit = shift && (fill_inc >= {1'b0, len}) &&
               ((hist_nx & mask) == (pattern & mask));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= hist_nx;
      if (restart) begin
        fill <= '0;
      end else if (fill_inc <= FILL_MAX) begin
        fill <= fill_inc[LEN_W-1:0];
      end
    end
  end

endmodule

// File: rtl/seq_match_ctrl.sv
// rtl/seq_match_ctrl.sv - programmable serial pattern-match controller with arm/stop and match target
module seq_match_ctrl
  import seq_match_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             stop,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             cfg_err
);

  state_t           state;
  state_t           state_nx;
  logic [PAT_W-1:0] pattern_r;
  logic [LEN_W-1:0] len_r;
  logic             overlap_r;
  logic [CNT_W-1:0] target_r;
  logic [CNT_W-1:0] cnt_inc;
  logic             len_ok;
  logic             shift;
  logic             hit;
  logic             restart;
  logic             target_hit;

  assign len_ok  = len_legal(int'(len_r), PAT_W);
  // A stop in the same cycle as a bit suppresses that bit entirely.
  assign shift   = (state == RUN) && bit_valid && !stop;
  assign restart = hit && !overlap_r;
  assign cnt_inc = (&match_cnt) ? match_cnt : match_cnt + CNT_W'(1);
  assign target_hit = hit && (target_r != '0) && (cnt_inc == target_r);

  seq_window_cmp #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W)
  ) u_window (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == ARM),
    .shift  (shift),
    .restart(restart),
    .bit_in (bit_in),
    .pattern(pattern_r),
    .len    (len_r),
    .hit    (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start && len_ok) state_nx = ARM;
      ARM:     state_nx = RUN;
      RUN: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (target_hit) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      match     <= 1'b0;
      done      <= 1'b0;
      match_cnt <= '0;
      cfg_err   <= 1'b0;
      pattern_r <= '0;
      len_r     <= '0;
      overlap_r <= 1'b0;
      target_r  <= '0;
    end else begin
      // busy trails DONE by a cycle so it stays high alongside the done pulse.
      busy  <= (state_nx != IDLE) || (state == DONE);
      match <= hit;
      done  <= (state == DONE);
      if (state == IDLE && start) begin
        cfg_err <= !len_ok;
      end
      if (state == IDLE && cfg_we && !start) begin
        pattern_r <= cfg_pattern;
        len_r     <= cfg_len;
        overlap_r <= cfg_overlap;
        target_r  <= cfg_target;
      end
      if (state == ARM) begin
        match_cnt <= '0;
      end else if (hit) begin
        match_cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// tb/tb_seq_match_ctrl.sv - directed and randomized bench for seq_match_ctrl against a queue-based model
module tb_seq_match_ctrl;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 8;
  localparam int P_IDLE = 0, P_ARM = 1, P_RUN = 2, P_DONE = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             bit_in = 1'b0;
  logic             bit_valid = 1'b0;
  logic             busy;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             done;
  logic             cfg_err;

  always #5 clk = ~clk;

  seq_match_ctrl #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_target (cfg_target),
    .start      (start),
    .stop       (stop),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .match      (match),
    .match_cnt  (match_cnt),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  int checks = 0;
  int errors = 0;
  string tag = "reset";

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: configuration, run phase and the bits seen since the last window restart.
  int         m_ph;
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_tgt;
  int         m_cnt;
  bit         m_err;
  int         m_q[$];
  bit         e_busy, e_match, e_done;

  task automatic model_reset();
    m_ph = P_IDLE; m_pat = '0; m_len = 0; m_ovl = 0; m_tgt = 0;
    m_cnt = 0; m_err = 0; m_q.delete();
    e_busy = 0; e_match = 0; e_done = 0;
  endtask

  function automatic bit tail_matches();
    if (m_q.size() < m_len) return 0;
    for (int i = 0; i < m_len; i++) begin
      if (m_q[m_q.size()-1-i] != int'(m_pat[i])) return 0;
    end
    return 1;
  endfunction

  task automatic model_step();
    e_match = 0;
    e_done  = 0;
    case (m_ph)
      P_IDLE: begin
        e_busy = 0;
        if (start) begin
          if (m_len >= 1 && m_len <= PAT_W) begin
            m_err = 0; m_ph = P_ARM; e_busy = 1;
          end else begin
            m_err = 1;
          end
        end else if (cfg_we) begin
          m_pat = cfg_pattern; m_len = int'(cfg_len);
          m_ovl = cfg_overlap; m_tgt = int'(cfg_target);
        end
      end
      P_ARM: begin
        m_q.delete(); m_cnt = 0; m_ph = P_RUN; e_busy = 1;
      end
      P_RUN: begin
        e_busy = 1;
        if (stop) begin
          m_ph = P_IDLE; e_busy = 0;
        end else if (bit_valid) begin
          m_q.push_back(int'(bit_in));
          if (m_q.size() > PAT_W) void'(m_q.pop_front());
          if (tail_matches()) begin
            e_match = 1;
            if (m_cnt < 255) m_cnt++;
            if (!m_ovl) m_q.delete();
            if (m_tgt != 0 && m_cnt == m_tgt) m_ph = P_DONE;
          end
        end
      end
      default: begin
        e_done = 1; e_busy = 1; m_ph = P_IDLE;
      end
    endcase
  endtask

  task automatic cycle();
    if (rst_n) model_step(); else model_reset();
    @(posedge clk);
    #1;
    chk({tag, ".match"}, int'(match), int'(e_match));
    chk({tag, ".done"}, int'(done), int'(e_done));
    chk({tag, ".busy"}, int'(busy), int'(e_busy));
    chk({tag, ".cnt"}, int'(match_cnt), m_cnt);
    chk({tag, ".err"}, int'(cfg_err), int'(m_err));
  endtask

  task automatic configure(input logic [7:0] p, input int l, input bit o, input int t);
    cfg_we = 1; cfg_pattern = p; cfg_len = LEN_W'(l); cfg_overlap = o; cfg_target = CNT_W'(t);
    cycle();
    cfg_we = 0;
  endtask

  task automatic do_start();
    start = 1;
    cycle();
    start = 0;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1; bit_in = b;
    cycle();
    bit_valid = 0;
  endtask

  task automatic send_stream();
    logic [6:0] s;
    s = 7'b1101101;
    for (int i = 6; i >= 0; i--) send_bit(s[i]);
  endtask

  task automatic do_stop();
    stop = 1;
    cycle();
    stop = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", int'(busy), 0);
    chk("reset.match", int'(match), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.cnt", int'(match_cnt), 0);
    chk("reset.err", int'(cfg_err), 0);
    rst_n = 1;

    tag = "overlap";
    configure(8'b1101, 4, 1, 0);
    do_start();
    send_bit(1'b1);
    send_stream();
    cycle();
    chk("overlap.total", int'(match_cnt), 2);
    do_stop();

    tag = "nonoverlap";
    configure(8'b1101, 4, 0, 0);
    do_start();
    cycle();
    send_stream();
    cycle();
    chk("nonoverlap.total", int'(match_cnt), 1);
    do_stop();

    tag = "target";
    configure(8'b1101, 4, 1, 2);
    do_start();
    cycle();
    send_stream();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("target.total", int'(match_cnt), 2);
    chk("target.idle", int'(busy), 0);

    tag = "badlen";
    configure(8'b0101, 0, 0, 0);
    do_start();
    chk("badlen.err", int'(cfg_err), 1);
    chk("badlen.busy", int'(busy), 0);
    configure(8'b0101, 3, 0, 0);
    do_start();
    chk("badlen.clear", int'(cfg_err), 0);
    do_stop();

    tag = "start_we";
    cfg_we = 1; cfg_len = 4'd0;
    do_start();
    cfg_we = 0;
    chk("start_we.busy", int'(busy), 1);
    do_stop();

    tag = "stopcol";
    configure(8'b1101, 4, 0, 0);
    do_start();
    cycle();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    stop = 1;
    send_bit(1'b1);
    stop = 0;
    chk("stopcol.match", int'(match), 0);
    chk("stopcol.cnt", int'(match_cnt), 0);
    chk("stopcol.busy", int'(busy), 0);

    tag = "midrst";
    configure(8'b101, 3, 1, 0);
    do_start();
    cycle();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("midrst.pre", int'(match), 1);
    rst_n = 0;
    #1;
    chk("midrst.match", int'(match), 0);
    chk("midrst.cnt", int'(match_cnt), 0);
    chk("midrst.busy", int'(busy), 0);
    model_reset();
    cycle();
    rst_n = 1;
    configure(8'b101, 3, 1, 0);
    do_start();
    cycle();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("midrst.recount", int'(match_cnt), 1);
    do_stop();

    tag = "rand";
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = int'($urandom_range(0, 19));
      cfg_we = ($urandom_range(0, 9) == 0);
      cfg_pattern = 8'($urandom);
      if (r == 0) cfg_len = 4'd0;
      else if (r == 1) cfg_len = 4'($urandom_range(9, 15));
      else if (r < 12) cfg_len = 4'($urandom_range(1, 3));
      else cfg_len = 4'($urandom_range(1, 8));
      cfg_overlap = 1'($urandom);
      cfg_target = 8'($urandom_range(0, 4));
      start = ($urandom_range(0, 11) == 0);
      stop = ($urandom_range(0, 39) == 0);
      bit_valid = ($urandom_range(0, 9) < 7);
      bit_in = 1'($urandom);
      cycle();
    end
    cfg_we = 0; start = 0; stop = 0; bit_valid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
